// File: rtl/fmul_cdb_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fmul_cdb_buffer
//  Description : Issue/writeback wrapper around a pipelined FP multiplier.
//                Accepts tagged ops from the FP reservation station, issues
//                them to the multiplier, re-attaches tags to results through
//                in-order completion and buffers {tag,result,exception} for
//                the CDB behind a valid/ready handshake. Credit based: an op
//                is only issued when a result slot is guaranteed.
//  Option      : FMUL_CDB_BYPASS_EN - present a non-dropped result on the CDB
//                in its mul_done cycle when the FIFO is empty and the CDB is
//                ready, skipping the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module fmul_cdb_buffer #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             flush,
    output logic             mul_start,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_result,
    input  logic             mul_done,
    input  logic             mul_exception,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    output logic             cdb_exc,
    output logic             err_orphan
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = TAG_W + 33;
    localparam int c_crd_w = c_cnt_w + 1;
    localparam logic [c_crd_w-1:0] c_depth = c_crd_w'(DEPTH);

    // Tag queue: tags of issued ops still waiting for their mul_done.
    logic [TAG_W-1:0]   tagq_mem_q [DEPTH];
    logic [TAG_W-1:0]   tagq_mem_d [DEPTH];
    logic [c_ptr_w-1:0] tagq_wr_q, tagq_wr_d;
    logic [c_ptr_w-1:0] tagq_rd_q, tagq_rd_d;
    logic [c_cnt_w-1:0] tagq_cnt_q, tagq_cnt_d;

    // Result FIFO: {tag, result, exception} waiting for a CDB grant.
    logic [c_ent_w-1:0] fifo_mem_q [DEPTH];
    logic [c_ent_w-1:0] fifo_mem_d [DEPTH];
    logic [c_ptr_w-1:0] fifo_wr_q, fifo_wr_d;
    logic [c_ptr_w-1:0] fifo_rd_q, fifo_rd_d;
    logic [c_cnt_w-1:0] fifo_cnt_q, fifo_cnt_d;

    // Number of upcoming completions that belong to flushed ops.
    logic [c_cnt_w-1:0] drop_cnt_q, drop_cnt_d;

    logic               mul_start_q, mul_start_d;
    logic [31:0]        mul_a_q, mul_a_d;
    logic [31:0]        mul_b_q, mul_b_d;
    logic               err_orphan_q, err_orphan_d;

    logic [c_crd_w-1:0] w_credits;
    logic               w_accept;
    logic               w_tagq_empty;
    logic               w_tagq_pop;
    logic               w_orphan;
    logic               w_drop;
    logic               w_keep;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic [c_ent_w-1:0] w_new_ent;
    logic [c_ent_w-1:0] w_cdb_ent;
`ifdef FMUL_CDB_BYPASS_EN
    logic               w_bypass;
`endif

    // Handshake and completion decode; tag queue entries cover every op
    // between issue and completion, the FIFO covers completed ones.
    always_comb begin
        w_credits    = c_crd_w'(tagq_cnt_q) + c_crd_w'(fifo_cnt_q);
        req_ready    = (w_credits < c_depth) && !flush;
        w_accept     = req_valid && req_ready;
        w_tagq_empty = (tagq_cnt_q == '0);
        w_tagq_pop   = mul_done && !w_tagq_empty;
        w_orphan     = mul_done && w_tagq_empty;
        w_drop       = w_tagq_pop && (drop_cnt_q != '0);
        w_keep       = w_tagq_pop && !w_drop && !flush;
        w_fifo_empty = (fifo_cnt_q == '0);
        w_fifo_full  = (fifo_cnt_q == c_cnt_w'(DEPTH));
        w_fifo_pop   = !w_fifo_empty && cdb_ready;
        w_new_ent    = {tagq_mem_q[tagq_rd_q], mul_result, mul_exception};
`ifdef FMUL_CDB_BYPASS_EN
        w_bypass     = w_keep && w_fifo_empty && cdb_ready;
        w_fifo_push  = w_keep && !w_bypass;
`else
        w_fifo_push  = w_keep;
`endif
    end

    // CDB presentation: FIFO head, or the live completion when bypassing.
    always_comb begin
        w_cdb_ent = '0;
        cdb_valid = 1'b0;
        if (!w_fifo_empty) begin
            w_cdb_ent = fifo_mem_q[fifo_rd_q];
            cdb_valid = 1'b1;
        end
`ifdef FMUL_CDB_BYPASS_EN
        else if (w_bypass) begin
            w_cdb_ent = w_new_ent;
            cdb_valid = 1'b1;
        end
`endif
    end

    assign cdb_tag    = w_cdb_ent[c_ent_w-1 -: TAG_W];
    assign cdb_data   = w_cdb_ent[32:1];
    assign cdb_exc    = w_cdb_ent[0];
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign err_orphan = err_orphan_q;

    // Tag queue next state: push on accept, pop on every matched completion.
    always_comb begin
        tagq_mem_d = tagq_mem_q;
        tagq_wr_d  = tagq_wr_q;
        tagq_rd_d  = tagq_rd_q;
        if (w_accept) begin
            tagq_mem_d[tagq_wr_q] = req_tag;
            tagq_wr_d             = tagq_wr_q + c_ptr_w'(1);
        end
        if (w_tagq_pop) begin
            tagq_rd_d = tagq_rd_q + c_ptr_w'(1);
        end
        tagq_cnt_d = tagq_cnt_q + c_cnt_w'(w_accept) - c_cnt_w'(w_tagq_pop);
    end

    // Drop accounting: a flush marks everything still owed by the multiplier
    // (after this edge's completion) as garbage to be discarded on arrival.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = tagq_cnt_q - c_cnt_w'(w_tagq_pop);
        end else if (w_drop) begin
            drop_cnt_d = drop_cnt_q - c_cnt_w'(1);
        end
    end

    // Result FIFO next state; flush empties it outright.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (flush) begin
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (w_fifo_push) begin
                fifo_mem_d[fifo_wr_q] = w_new_ent;
                fifo_wr_d             = fifo_wr_q + c_ptr_w'(1);
            end
            if (w_fifo_pop) begin
                fifo_rd_d = fifo_rd_q + c_ptr_w'(1);
            end
            fifo_cnt_d = fifo_cnt_q + c_cnt_w'(w_fifo_push) - c_cnt_w'(w_fifo_pop);
        end
    end

    // Multiplier issue registers and the sticky orphan-completion flag.
    always_comb begin
        mul_start_d  = w_accept;
        mul_a_d      = w_accept ? req_a : mul_a_q;
        mul_b_d      = w_accept ? req_b : mul_b_q;
        err_orphan_d = err_orphan_q || w_orphan;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tagq_wr_q    <= '0;
            tagq_rd_q    <= '0;
            tagq_cnt_q   <= '0;
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            fifo_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            tagq_wr_q    <= tagq_wr_d;
            tagq_rd_q    <= tagq_rd_d;
            tagq_cnt_q   <= tagq_cnt_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_cnt_q   <= fifo_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            mul_start_q  <= mul_start_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Storage arrays need no reset: contents are only visible behind counts.
    always_ff @(posedge clk) begin
        tagq_mem_q <= tagq_mem_d;
        fifo_mem_q <= fifo_mem_d;
    end

    // Credit accounting must make a push into a full FIFO unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(w_fifo_push && w_fifo_full));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_cdb_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fmul_cdb_buffer
//  Description : Self-checking bench for fmul_cdb_buffer. Models a 3-stage
//                FP multiplier, keeps an issue-order scoreboard of expected
//                CDB beats, runs directed corner sequences and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_cdb_buffer;

    localparam int TAG_W = 6;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    wire              req_ready;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic             flush = 1'b0;
    wire              mul_start;
    wire  [31:0]      mul_a;
    wire  [31:0]      mul_b;
    logic [31:0]      mul_result = '0;
    wire              mul_done;
    logic             mul_exception = 1'b0;
    logic             m_done = 1'b0;
    logic             force_done = 1'b0;
    wire              cdb_valid;
    logic             cdb_ready = 1'b0;
    wire  [TAG_W-1:0] cdb_tag;
    wire  [31:0]      cdb_data;
    wire              cdb_exc;
    wire              err_orphan;

    assign mul_done = m_done | force_done;

    always #5 clk = ~clk;

    fmul_cdb_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done), .mul_exception(mul_exception),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_exc(cdb_exc), .err_orphan(err_orphan)
    );

    // ---------------- IEEE single multiply via real arithmetic ----------------
    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {exception, result}; exact for the operands used here.
    function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        real         p;
        logic [63:0] d;
        int          e;
        p = sp2real(a) * sp2real(b);
        d = $realtobits(p);
        if (d[62:0] == 63'd0) return {1'b0, d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {1'b1, d[63], 31'd0};
        return {1'b0, d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(40, 215)), 23'($urandom)};
    endfunction

    // ---------------- multiplier model: fixed latency, in order ----------------
    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
    } mop_t;
    mop_t mq[$];
    int   cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            m_done = 1'b0;
            if (!rst_n) begin
                mq.delete();
            end else begin
                if (mul_start) mq.push_back('{cyc + LAT, mul_a, mul_b});
                if (mq.size() > 0 && mq[0].due == cyc) begin
                    {mul_exception, mul_result} = fp_mul(mq[0].a, mq[0].b);
                    m_done = 1'b1;
                    void'(mq.pop_front());
                end
            end
        end
    end

    // ---------------- scoreboard and per-cycle sampling ----------------
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [32:0]      r;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      d;
        logic             exc;
    } vec_t;
    vec_t tv[5];

    int n_vec  = 0;
    int n_fail = 0;

    logic             s_req_ready, s_accept, s_mul_start, s_mul_done, s_pop;
    logic [31:0]      s_mul_a, s_mul_b, s_cdb_data;
    logic             s_cdb_valid, s_cdb_exc, s_err;
    logic [TAG_W-1:0] s_cdb_tag;
    logic             p_hold = 1'b0;
    logic [38:0]      p_payload = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, expv);
        end
    endtask

    `define CHK(nm, a, e) chk(nm, 64'(a), 64'(e))

    // Called with inputs already applied for this cycle; samples, updates the
    // scoreboard, and returns one cycle later just after the falling edge.
    task automatic step();
        #1;
        s_req_ready = req_ready;
        s_mul_start = mul_start;
        s_mul_a     = mul_a;
        s_mul_b     = mul_b;
        s_mul_done  = mul_done;
        s_cdb_valid = cdb_valid;
        s_cdb_tag   = cdb_tag;
        s_cdb_data  = cdb_data;
        s_cdb_exc   = cdb_exc;
        s_err       = err_orphan;
        s_accept    = rst_n && req_valid && req_ready;
        s_pop       = rst_n && cdb_valid && cdb_ready;
        if (p_hold) begin
            `CHK("cdb_hold_valid", cdb_valid, 1'b1);
            `CHK("cdb_hold_payload", {cdb_tag, cdb_data, cdb_exc}, p_payload);
        end
        if (flush) `CHK("req_ready_in_flush", req_ready, 1'b0);
        if (s_pop) begin
            if (exp_q.size() == 0) begin
                `CHK("cdb_unexpected_beat", cdb_valid, 1'b0);
            end else begin
                `CHK("cdb_beat", {cdb_tag, cdb_exc, cdb_data}, {exp_q[0].tag, exp_q[0].r});
                void'(exp_q.pop_front());
            end
        end
        if (s_accept) exp_q.push_back('{req_tag, fp_mul(req_a, req_b)});
        if (flush || !rst_n) exp_q.delete();
        p_hold    = rst_n && !flush && cdb_valid && !cdb_ready;
        p_payload = {cdb_tag, cdb_data, cdb_exc};
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        #1;
        `CHK("rst_req_ready", req_ready, 1'b1);
        `CHK("rst_mul_start", mul_start, 1'b0);
        `CHK("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        `CHK("rst_cdb_valid", cdb_valid, 1'b0);
        `CHK("rst_cdb_payload", {cdb_tag, cdb_data, cdb_exc}, 39'd0);
        `CHK("rst_err_orphan", err_orphan, 1'b0);
    endtask

    // One op issued alone with the CDB ready; checks issue and writeback timing.
    task automatic run_single(input vec_t v);
        bit seen;
        cdb_ready = 1'b1;
        req_valid = 1'b1; req_tag = v.tag; req_a = v.a; req_b = v.b;
        step();
        `CHK("single_accept", s_accept, 1'b1);
        req_valid = 1'b0;
        step();
        `CHK("single_mul_start", s_mul_start, 1'b1);
        `CHK("single_mul_ops", {s_mul_a, s_mul_b}, {v.a, v.b});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_mul_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            `CHK("single_done_timeout", s_mul_done, 1'b1);
        end else begin
`ifdef FMUL_CDB_BYPASS_EN
            `CHK("single_bypass_beat", {s_cdb_valid, s_cdb_tag, s_cdb_data, s_cdb_exc},
                 {1'b1, v.tag, v.d, v.exc});
            step();
            `CHK("single_idle_after", s_cdb_valid, 1'b0);
`else
            `CHK("single_no_early_valid", s_cdb_valid, 1'b0);
            step();
            `CHK("single_beat", {s_cdb_valid, s_cdb_tag, s_cdb_data, s_cdb_exc},
                 {1'b1, v.tag, v.d, v.exc});
            step();
            `CHK("single_idle_after", s_cdb_valid, 1'b0);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, nb, lastk, nd;
        bit seen;
        int rmode;

        tv[0] = '{6'd5,  32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0};
        tv[1] = '{6'd1,  32'h40000000, 32'h40400000, 32'h40C00000, 1'b0};
        tv[2] = '{6'd2,  32'h40800000, 32'h3F000000, 32'h40000000, 1'b0};
        tv[3] = '{6'd3,  32'h41200000, 32'h41200000, 32'h42C80000, 1'b0};
        tv[4] = '{6'd9,  32'h42C80000, 32'h00000000, 32'h00000000, 1'b0};

        @(negedge clk);
        #1;
        step();
        step();
        chk_reset_state();
        rst_n = 1'b1;
        step();

        // 1: single op
        run_single(tv[0]);

        // 2: back-to-back ops emerge as consecutive beats in tag order
        cdb_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req_tag = tv[i].tag; req_a = tv[i].a; req_b = tv[i].b;
            step();
            `CHK("b2b_accept", s_accept, 1'b1);
        end
        req_valid = 1'b0;
        nb = 0; lastk = 0;
        for (int k = 0; k < 30 && nb < 3; k++) begin
            step();
            if (s_pop) begin
                n_vec++;
                if ({s_cdb_tag, s_cdb_data} !== {tv[nb + 1].tag, tv[nb + 1].d}) begin
                    n_fail++;
                    $display("FAIL b2b_beat: actual %0h/%0h required %0h/%0h",
                             s_cdb_tag, s_cdb_data, tv[nb + 1].tag, tv[nb + 1].d);
                end
                if (nb > 0) `CHK("b2b_consecutive", k - lastk, 1);
                lastk = k;
                nb++;
            end
        end
        `CHK("b2b_beat_count", nb, 3);

        // 3: credit limit with a stalled CDB, then release
        cdb_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 20; k++) begin
            req_valid = 1'b1;
            req_tag = 6'(10 + n_acc);
            req_a = 32'h3F800000 + (n_acc << 20);
            req_b = 32'h40000000;
            step();
            if (s_accept) n_acc++;
        end
        n_vec++;
        if (n_acc != DEPTH) begin
            n_fail++;
            $display("FAIL credit_accept_cap: actual %0d required %0d", n_acc, DEPTH);
        end
        n_vec++;
        if (s_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_ready_low: actual %0b required 0", s_req_ready);
        end
        cdb_ready = 1'b1;
        nb = 0;
        for (int k = 0; k < 100 && nb < 10; k++) begin
            req_valid = (n_acc < 10);
            req_tag = 6'(10 + n_acc);
            req_a = 32'h3F800000 + (n_acc << 20);
            req_b = 32'h40000000;
            step();
            if (s_accept) n_acc++;
            if (s_pop) nb++;
        end
        req_valid = 1'b0;
        n_vec++;
        if (n_acc != 10) begin
            n_fail++;
            $display("FAIL credit_total_accepts: actual %0d required 10", n_acc);
        end
        n_vec++;
        if (nb != 10) begin
            n_fail++;
            $display("FAIL credit_total_beats: actual %0d required 10", nb);
        end
        `CHK("credit_sb_empty", exp_q.size(), 0);

        // 4: flush with one result queued and two ops in flight
        cdb_ready = 1'b0;
        req_valid = 1'b1; req_tag = 6'd20; req_a = tv[0].a; req_b = tv[0].b;
        step();
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_cdb_valid) begin
                seen = 1'b1;
                break;
            end
        end
        `CHK("flush_first_queued", s_cdb_valid, 1'b1);
        req_valid = 1'b1; req_tag = 6'd21; req_a = tv[1].a; req_b = tv[1].b;
        step();
        req_tag = 6'd22; req_a = tv[2].a; req_b = tv[2].b;
        step();
        flush = 1'b1; req_tag = 6'd23;
        step();
        `CHK("flush_ready_low", s_req_ready, 1'b0);
        `CHK("flush_no_accept", s_accept, 1'b0);
        flush = 1'b0; req_valid = 1'b0; cdb_ready = 1'b1;
        nd = 0; nb = 0;
        step();
        `CHK("flush_cdb_empty", s_cdb_valid, 1'b0);
        `CHK("flush_ready_resumes", s_req_ready, 1'b1);
        if (s_mul_done) nd++;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_mul_done) nd++;
            if (s_pop) nb++;
        end
        n_vec++;
        if (nd != 2) begin
            n_fail++;
            $display("FAIL flush_dones_seen: actual %0d required 2", nd);
        end
        n_vec++;
        if (nb != 0) begin
            n_fail++;
            $display("FAIL flush_dropped_beats: actual %0d required 0", nb);
        end
        run_single(tv[4]);

        // 5: completion with nothing outstanding
        `CHK("orphan_clear_before", s_err, 1'b0);
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        step();
        n_vec++;
        if (s_err !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_set: actual %0b required 1", s_err);
        end
        `CHK("orphan_no_valid", s_cdb_valid, 1'b0);
        for (int k = 0; k < 5; k++) step();
        `CHK("orphan_sticky", s_err, 1'b1);
        `CHK("orphan_still_no_valid", s_cdb_valid, 1'b0);

        // 6: reset with three ops in flight
        cdb_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req_tag = tv[i].tag; req_a = tv[i].a; req_b = tv[i].b;
            step();
        end
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_state();
        cdb_ready = 1'b1;
        nd = 0; nb = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_mul_done) nd++;
            if (s_pop) nb++;
        end
        `CHK("reset_no_dones", nd, 0);
        `CHK("reset_no_beats", nb, 0);
        run_single(tv[0]);

        // Random traffic against the scoreboard
        rmode = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 128 == 0) rmode = int'($urandom_range(0, 2));
            req_valid = 1'(($urandom % 4) != 0);
            req_tag   = 6'($urandom);
            req_a     = rand_fp();
            req_b     = rand_fp();
            case (rmode)
                0:       cdb_ready = 1'b1;
                1:       cdb_ready = 1'($urandom % 2);
                default: cdb_ready = 1'(($urandom % 8) == 0);
            endcase
            flush = 1'(($urandom % 64) == 0);
            step();
        end
        flush = 1'b0; req_valid = 1'b0; cdb_ready = 1'b1;
        for (int k = 0; k < 40; k++) step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_sb_empty: actual %0d required 0", exp_q.size());
        end
        n_vec++;
        if (s_cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_cdb_idle: actual %0b required 0", s_cdb_valid);
        end
        `CHK("drain_no_orphan", s_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    `undef CHK

endmodule
`default_nettype wire
